// File: rtl/cpu_phase_sequencer.sv
// Phase generator and run/step/halt sequencer for the combinational CPU controller.
// Stretches memory-read phases until mem_ready_i and counts retired instructions.
module cpu_phase_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          STALL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             stop_i,
  input  logic             halt_i,
  input  logic             mem_ready_i,
  output logic [2:0]       phase_o,
  output logic             running_o,
  output logic             halted_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] icount_o
);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

  state_e             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic               stop_pend_q, stop_pend_d;
  logic               instr_done_q, instr_done_d;
  logic [CNT_W-1:0]   icount_q, icount_d;
  logic               running_q, halted_q;
  logic               stall;
  logic               retire;

  // Phases 1 and 5 are the memory-read phases for every opcode.
  assign stall = STALL_EN && ((phase_q == 3'd1) || (phase_q == 3'd5)) && !mem_ready_i;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    stop_pend_d  = stop_pend_q;
    retire       = 1'b0;
    unique case (state_q)
      StIdle, StHalted: begin
        phase_d     = 3'd0;
        stop_pend_d = 1'b0;
        if (run_i) begin
          state_d = StRun;
        end else if (step_i) begin
          state_d = StStep;
        end
      end
      StRun, StStep: begin
        if (stall) begin
          if (state_q == StRun && stop_i) stop_pend_d = 1'b1;
        end else if (phase_q == 3'd4 && halt_i) begin
          state_d     = StHalted;
          phase_d     = 3'd0;
          stop_pend_d = 1'b0;
          retire      = 1'b1;
        end else if (phase_q == 3'd7) begin
          phase_d = 3'd0;
          retire  = 1'b1;
          if (state_q == StStep || stop_pend_q || stop_i) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + 3'd1;
          if (state_q == StRun && stop_i) stop_pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_done_d = retire;
    icount_d     = icount_q;
    if (retire && (icount_q != {CNT_W{1'b1}})) begin
      icount_d = icount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= 3'd0;
      stop_pend_q  <= 1'b0;
      instr_done_q <= 1'b0;
      icount_q     <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      stop_pend_q  <= stop_pend_d;
      instr_done_q <= instr_done_d;
      icount_q     <= icount_d;
      running_q    <= (state_d == StRun) || (state_d == StStep);
      halted_q     <= (state_d == StHalted);
    end
  end

  assign phase_o      = phase_q;
  assign running_o    = running_q;
  assign halted_o     = halted_q;
  assign instr_done_o = instr_done_q;
  assign icount_o     = icount_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: vector table on the default instance plus
// hand sequences for the no-stall and saturating-counter variants.
module tb_cpu_phase_sequencer;

  logic clk = 1'b0;
  logic rst, run, step, stop, halt, mem_ready;

  logic [2:0]  ph0, ph1, ph2;
  logic        rn0, rn1, rn2, hl0, hl1, hl2, dn0, dn1, dn2;
  logic [15:0] ic0, ic1;
  logic [1:0]  ic2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_phase_sequencer #(.CNT_W(16), .STALL_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .run_i(run), .step_i(step), .stop_i(stop), .halt_i(halt),
    .mem_ready_i(mem_ready), .phase_o(ph0), .running_o(rn0), .halted_o(hl0),
    .instr_done_o(dn0), .icount_o(ic0)
  );

  cpu_phase_sequencer #(.CNT_W(16), .STALL_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .run_i(run), .step_i(step), .stop_i(stop), .halt_i(halt),
    .mem_ready_i(mem_ready), .phase_o(ph1), .running_o(rn1), .halted_o(hl1),
    .instr_done_o(dn1), .icount_o(ic1)
  );

  cpu_phase_sequencer #(.CNT_W(2), .STALL_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .run_i(run), .step_i(step), .stop_i(stop), .halt_i(halt),
    .mem_ready_i(mem_ready), .phase_o(ph2), .running_o(rn2), .halted_o(hl2),
    .instr_done_o(dn2), .icount_o(ic2)
  );

  typedef struct {
    logic        rst, run, step, stop, halt, mem;
    logic [2:0]  phase;
    logic        running, halted, done;
    logic [15:0] icount;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rn, input logic st, input logic sp,
                     input logic h, input logic m, input int p, input logic erun,
                     input logic ehlt, input logic edn, input int eic);
    vec_t v;
    v.rst = r; v.run = rn; v.step = st; v.stop = sp; v.halt = h; v.mem = m;
    v.phase = 3'(p); v.running = erun; v.halted = ehlt; v.done = edn;
    v.icount = 16'(eic);
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; run = 1'b0; step = 1'b0; stop = 1'b0; halt = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int dones;
    bit seen;

    // rst run stp stop hlt mem | phase running halted done icount
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int p = 1; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
    for (int p = 1; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2);
    // stop at phase 3 finishes the instruction, then idles
    for (int p = 1; p <= 3; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 2);
    add(0, 0, 0, 1, 0, 1, 4, 1, 0, 0, 2);
    for (int p = 5; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    // single step
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 3);
    for (int p = 1; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4);
    // halt ignored at phase 2, taken at phase 4
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 4);
    for (int p = 1; p <= 2; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 1, 3, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 5);
    for (int p = 1; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 5);
    // stop on the boundary edge itself
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 6);
    // run and step together start RUN, which keeps going past the boundary
    add(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 6);
    for (int p = 1; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 6);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 7);
    // stall 3 cycles in phase 1, 2 cycles in phase 5
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 7);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7);
    for (int p = 2; p <= 5; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 7);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 7);
    for (int p = 6; p <= 7; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8);
    // reset while stalled in phase 5
    for (int p = 1; p <= 5; p++) add(0, 0, 0, 0, 0, 1, p, 1, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    idle_inputs();
    tick();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; run = vecs[i].run; step = vecs[i].step;
      stop = vecs[i].stop; halt = vecs[i].halt; mem_ready = vecs[i].mem;
      tick();
      checks++;
      if (ph0 !== vecs[i].phase || rn0 !== vecs[i].running || hl0 !== vecs[i].halted ||
          dn0 !== vecs[i].done || ic0 !== vecs[i].icount) begin
        errors++;
        $display("FAIL vec%0d: got ph=%0d run=%b hlt=%b done=%b ic=%0d expected ph=%0d run=%b hlt=%b done=%b ic=%0d",
                 i, ph0, rn0, hl0, dn0, ic0, vecs[i].phase, vecs[i].running,
                 vecs[i].halted, vecs[i].done, vecs[i].icount);
      end
    end

    // STALL_EN=0 ignores mem_ready: 8 cycles; the stalling instance sits in phase 1
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 20) begin
      tick();
      cnt++;
      if (dn1 === 1'b1) seen = 1'b1;
    end
    check("nostall_len", cnt, 8);
    check("nostall_icount", int'(ic1), 1);
    check("stall_hold_phase", int'(ph0), 1);
    check("stall_hold_icount", int'(ic0), 0);

    // CNT_W=2 saturates at 3 while instr_done keeps pulsing
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dn2 === 1'b1) dones++;
    end
    check("sat_done_pulses", dones, 5);
    check("sat_icount", int'(ic2), 3);
    check("wide_icount", int'(ic0), 5);
    check("sat_running", int'(rn2), 1);

    // two consecutive single steps
    do_reset();
    for (int s = 1; s <= 2; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("step_icount", int'(ic0), s);
      check("step_running", int'(rn0), 0);
      check("step_phase", int'(ph0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
